// File: rtl/vga_sync_if.sv
// Raster timing bundle from vga_sync_gen to the graphics generators and VGA pins.
// frame_tick is present only when VGA_FRAME_TICK_EN is defined.
interface vga_sync_if;
    logic       p_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
`ifdef VGA_FRAME_TICK_EN
    logic       frame_tick;

    modport master (
        output p_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_tick
    );
    modport slave (
        input  p_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_tick
    );
`else
    modport master (
        output p_tick, hsync, vsync, video_on, pixel_x, pixel_y
    );
    modport slave (
        input  p_tick, hsync, vsync, video_on, pixel_x, pixel_y
    );
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-tick divider, 10-bit x/y counters, registered syncs.
// Optional VGA_FRAME_TICK_EN adds a one-clk frame_tick at entry to vertical blank.
module vga_sync_gen #(
    parameter int unsigned TICK_DIV  = 4,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master vga
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS       = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS       = 10'(V_DISPLAY);
    localparam logic [9:0] V_VIS_LAST  = 10'(V_DISPLAY - 1);
    localparam logic [9:0] HS_FIRST    = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST     = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST    = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST     = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic       p_tick;
    logic       line_end;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;

    // Pixel-tick divider; with TICK_DIV=1 every clk is a pixel period.
    generate
        if (TICK_DIV == 1) begin : g_no_div
            assign p_tick = 1'b1;
        end else begin : g_div
            localparam int unsigned DW = $clog2(TICK_DIV);
            localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

            logic [DW-1:0] div_cnt_q, div_cnt_d;

            always_comb begin
                div_cnt_d = div_cnt_q + 1'b1;
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    div_cnt_q <= '0;
                end else begin
                    div_cnt_q <= div_cnt_d;
                end
            end

            assign p_tick = (div_cnt_q == DIV_LAST);
        end
    endgenerate

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        line_end = 1'b0;
        if (p_tick) begin
            if (x_q == H_LAST) begin
                x_d      = '0;
                line_end = 1'b1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        if (line_end) begin
            if (y_q == V_LAST) begin
                y_d = '0;
            end else begin
                y_d = y_q + 10'd1;
            end
        end
        // Syncs decode the next-state counts so they line up with pixel_x/pixel_y.
        hsync_d = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
        vsync_d = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    logic frame_tick_q, frame_tick_d;

    assign frame_tick_d = p_tick && (x_q == H_LAST) && (y_q == V_VIS_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vga.frame_tick = frame_tick_q;
`endif

    assign vga.p_tick   = p_tick;
    assign vga.hsync    = hsync_q;
    assign vga.vsync    = vsync_q;
    assign vga.pixel_x  = x_q;
    assign vga.pixel_y  = y_q;
    assign vga.video_on = (x_q < H_VIS) && (y_q < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboarded bench for vga_sync_gen on a shrunken raster (30x19), TICK_DIV=4 and TICK_DIV=1.
// Expected raster state is derived from the number of clks since reset release.
module tb_vga_sync_gen;

    localparam int unsigned TD = 4;
    localparam int unsigned HD = 16, HF = 4, HS = 6, HB = 4;
    localparam int unsigned VD = 12, VF = 2, VS = 2, VB = 3;
    localparam int unsigned HT = HD + HF + HS + HB;
    localparam int unsigned VT = VD + VF + VS + VB;
    localparam int unsigned FT = HT * VT;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
        logic       ft;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int unsigned k0 = 0;
    exp_t q0[$];
    exp_t q1[$];

    vga_sync_if vif0();
    vga_sync_if vif1();

    vga_sync_gen #(
        .TICK_DIV(TD), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .vga  (vif0)
    );

    vga_sync_gen #(
        .TICK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) u_dut1 (
        .clk  (clk),
        .reset(reset),
        .vga  (vif1)
    );

    always #5 clk = ~clk;

    // Raster state after k clk edges since release: tick count = k / td.
    function automatic exp_t model(input int unsigned k, input int unsigned td);
        exp_t e;
        int unsigned t, x, y;
        t = k / td;
        x = t % HT;
        y = (t / HT) % VT;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.hs  = !(x >= HD + HF && x < HD + HF + HS);
        e.vs  = !(y >= VD + VF && y < VD + VF + VS);
        e.von = (x < HD) && (y < VD);
        e.pt  = (td == 1) ? 1'b1 : ((k % td) == td - 1);
`ifdef VGA_FRAME_TICK_EN
        e.ft  = (k > 0) && ((k % td) == 0) && ((t % FT) == VD * HT);
`else
        e.ft  = 1'b0;
`endif
        return e;
    endfunction

    function automatic exp_t sample0();
        exp_t a;
        a.x = vif0.pixel_x; a.y = vif0.pixel_y; a.hs = vif0.hsync; a.vs = vif0.vsync;
        a.von = vif0.video_on; a.pt = vif0.p_tick;
`ifdef VGA_FRAME_TICK_EN
        a.ft = vif0.frame_tick;
`else
        a.ft = 1'b0;
`endif
        return a;
    endfunction

    function automatic exp_t sample1();
        exp_t a;
        a.x = vif1.pixel_x; a.y = vif1.pixel_y; a.hs = vif1.hsync; a.vs = vif1.vsync;
        a.von = vif1.video_on; a.pt = vif1.p_tick;
`ifdef VGA_FRAME_TICK_EN
        a.ft = vif1.frame_tick;
`else
        a.ft = 1'b0;
`endif
        return a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus side: push the expected state for every clk edge.
    always @(posedge clk) begin
        if (reset) k0 = 0;
        else k0 = k0 + 1;
        q0.push_back(model(k0, TD));
        q1.push_back(model(k0, 1));
    end

    // Monitor side: pop and compare the full output bundle every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() == 0 || q1.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got size %0d/%0d expected >0", q0.size(), q1.size());
        end else begin
            e = q0.pop_front();
            check("sb_div4 {x,y,hs,vs,von,pt,ft}", 64'(sample0()), 64'(e));
            e = q1.pop_front();
            check("sb_div1 {x,y,hs,vs,von,pt,ft}", 64'(sample1()), 64'(e));
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_x"}, 64'(vif0.pixel_x), 64'd0);
        check({tag, "_y"}, 64'(vif0.pixel_y), 64'd0);
        check({tag, "_hsync"}, 64'(vif0.hsync), 64'd1);
        check({tag, "_vsync"}, 64'(vif0.vsync), 64'd1);
        check({tag, "_p_tick"}, 64'(vif0.p_tick), 64'd0);
        check({tag, "_x_div1"}, 64'(vif1.pixel_x), 64'd0);
        check({tag, "_p_tick_div1"}, 64'(vif1.p_tick), 64'd1);
`ifdef VGA_FRAME_TICK_EN
        check({tag, "_frame_tick"}, 64'(vif0.frame_tick), 64'd0);
`endif
    endtask

    // Called just after a negedge: asserts reset off-edge, holds, releases, checks restart.
    task automatic async_reset(input int unsigned hold, input string tag);
        #1 reset = 1'b1;
        #1 check_reset_values(tag);
        repeat (hold) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check({tag, "_resume_x"}, 64'(vif0.pixel_x), 64'd0);
        check({tag, "_resume_x_div1"}, 64'(vif1.pixel_x), 64'd1);
        repeat (TD) @(negedge clk);
        check({tag, "_resume_x_next"}, 64'(vif0.pixel_x), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned hs_low, vs_low, ticks, k, n;
        int first;
        hs_low = 0; vs_low = 0; ticks = 0; first = -1;

        repeat (3) begin
            @(negedge clk);
            check_reset_values("reset");
        end
        #1 reset = 1'b0;

        for (int i = 0; i < int'(FT * TD); i++) begin
            @(negedge clk);
            k = i + 1;
            if (vif0.p_tick) begin
                ticks++;
                if (first < 0) first = k;
                if (!vif0.hsync && k <= HT * TD) hs_low++;
                if (!vif0.vsync) vs_low++;
            end
            if (k == ((VD - 1) * HT + HD - 1) * TD)
                check("video_on_last_visible", 64'(vif0.video_on), 64'd1);
            if (k == HD * TD)
                check("video_on_first_hblank", 64'(vif0.video_on), 64'd0);
            if (k == VD * HT * TD)
                check("video_on_first_vblank", 64'(vif0.video_on), 64'd0);
            if (k == FT * TD - 1)
                check("last_pixel_xy", 64'({vif0.pixel_x, vif0.pixel_y}),
                      64'({10'(HT - 1), 10'(VT - 1)}));
        end
        check("first_tick_edges_after_release", 64'(first), 64'(TD - 1));
        check("ticks_per_frame", 64'(ticks), 64'(FT));
        check("hsync_low_ticks_line0", 64'(hs_low), 64'(HS));
        check("vsync_low_ticks_frame", 64'(vs_low), 64'(VS * HT));
        check("frame_wrap_xy", 64'({vif0.pixel_x, vif0.pixel_y}), 64'd0);

        // Targeted mid-line reset at (20,7).
        n = 0;
        while (((k0 / TD) % FT) != 7 * HT + 20 && n < FT * TD + 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= FT * TD + 8) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_position: got timeout expected position (20,7)");
        end
        check("pre_reset_xy", 64'({vif0.pixel_x, vif0.pixel_y}), 64'({10'd20, 10'd7}));
        async_reset(2, "mid_reset");

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(5, 2500)) @(negedge clk);
            async_reset($urandom_range(1, 5), "rand_reset");
        end

`ifdef VGA_FRAME_TICK_EN
        begin
            int unsigned ft_high, ft_bad;
            ft_high = 0; ft_bad = 0;
            @(negedge clk);
            async_reset(1, "ft_reset");
            for (int i = 0; i < int'(2 * FT * TD); i++) begin
                @(negedge clk);
                if (vif0.frame_tick) begin
                    ft_high++;
                    if (vif0.pixel_y != 10'(VD) || vif0.pixel_x != 10'd0) ft_bad++;
                end
            end
            check("frame_tick_high_cycles", 64'(ft_high), 64'd2);
            check("frame_tick_misaligned", 64'(ft_bad), 64'd0);
        end
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
